jk_bank_sequencer: RTL and testbench

Command-driven controller that sequences a WIDTH-bit bank of JK flip-flops. It translates clear, set, load, toggle and multi-step count commands into per-bit J/K drive vectors, and it holds the resulting state. It sits between a command master that uses a valid/ready handshake and the JK storage, which is internal and follows the standard JK next-state equation. It is the team's reusable sequencer for JK-based registers and counters.

---
 rtl/jk_bank_sequencer.sv | 71 +++++++
 tb/tb_jk_bank_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: command-driven J/K drive sequencer for a WIDTH-bit JK flip-flop bank
module jk_bank_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             wrap
);
    typedef enum logic [1:0] {IDLE, APPLY, COUNT, DONE} state_t;
    localparam logic [2:0] OP_CLEAR = 3'd1, OP_SET = 3'd2, OP_LOAD = 3'd3, OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_UP = 3'd5, OP_DOWN = 3'd6, OP_RSVD = 3'd7;
    state_t           state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] data_r, tq, t;
    logic [CNT_W-1:0] rem;
    // toggle bit i when every lower bit is 1 (up) or 0 (down)
    always_comb begin
        tq = (op_r == OP_UP) ? q : ~q;
        t = '0;
        for (int i = 0; i < WIDTH; i++) t[i] = &(tq | ~((WIDTH'(1) << i) - WIDTH'(1)));
    end
    assign j_out = (state == COUNT) ? t : (state != APPLY) ? '0 :
                   (op_r == OP_CLEAR) ? '0 : (op_r == OP_SET) ? '1 : data_r;
    assign k_out = (state == COUNT) ? t : (state != APPLY) ? '0 :
                   (op_r == OP_CLEAR) ? '1 : (op_r == OP_SET) ? '0 :
                   (op_r == OP_LOAD) ? ~data_r : data_r;
    assign cmd_ready = (state == IDLE);
    assign busy = (state == APPLY) || (state == COUNT);
    assign done = (state == DONE);
    assign err = done && (op_r == OP_RSVD);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            op_r   <= '0;
            data_r <= '0;
            rem    <= '0;
            q      <= '0;
            wrap   <= 1'b0;
        end else begin
            q    <= (j_out & ~q) | (~k_out & q);
            wrap <= (state == COUNT) && ((op_r == OP_UP) ? &q : ~|q);
            case (state)
                IDLE: if (cmd_valid) begin
                    op_r   <= cmd_op;
                    data_r <= cmd_data;
                    rem    <= cmd_count;
                    state  <= (cmd_op >= OP_CLEAR && cmd_op <= OP_TOGGLE) ? APPLY :
                              ((cmd_op == OP_UP || cmd_op == OP_DOWN) && cmd_count != '0) ? COUNT : DONE;
                end
                APPLY: state <= DONE;
                COUNT: begin
                    rem <= rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer: directed scenario bench for jk_bank_sequencer
module tb_jk_bank_sequencer;
    logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
    logic [2:0] cmd_op = '0;
    logic [7:0] cmd_data = '0, cmd_count = '0;
    logic       cmd_ready, busy, done, err, wrap;
    logic [7:0] j_out, k_out, q;
    int checks = 0, errors = 0;

    jk_bank_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
        .j_out(j_out), .k_out(k_out), .q(q), .busy(busy), .done(done),
        .err(err), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // presents a command at a negedge, returns at the negedge after the accept edge
    task automatic issue(input logic [2:0] op, input logic [7:0] data, input logic [7:0] cnt);
        cmd_op = op; cmd_data = data; cmd_count = cnt; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h3C; cmd_count = 8'hEE;
        @(negedge clk);
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        @(negedge clk);
        checks++; if ({q, j_out, k_out} !== 24'h0) begin errors++; $display("FAIL reset_qjk: got %h want 000000", {q, j_out, k_out}); end
        checks++; if ({busy, done, err, wrap} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err, wrap}); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic do_single_op(input string name, input logic [2:0] op, input logic [7:0] data,
                                input logic [7:0] ej, input logic [7:0] ek, input logic [7:0] eq);
        issue(op, data, 8'd0);
        checks++; if ({j_out, k_out} !== {ej, ek}) begin errors++; $display("FAIL %s_jk: got %h/%h want %h/%h", name, j_out, k_out, ej, ek); end
        checks++; if ({busy, cmd_ready, done} !== 3'b100) begin errors++; $display("FAIL %s_apply_flags: got %b want 100", name, {busy, cmd_ready, done}); end
        @(negedge clk);
        checks++; if (q !== eq) begin errors++; $display("FAIL %s_q: got %h want %h", name, q, eq); end
        checks++; if ({busy, cmd_ready, done, j_out} !== {3'b001, 8'h00}) begin errors++; $display("FAIL %s_done_flags: got %b %h want 001 00", name, {busy, cmd_ready, done}, j_out); end
        @(negedge clk);
        checks++; if ({cmd_ready, done, q} !== {2'b10, eq}) begin errors++; $display("FAIL %s_idle: got %b %h want 10 %h", name, {cmd_ready, done}, q, eq); end
    endtask

    task automatic test_load_toggle;
        do_single_op("load_a5", 3'd3, 8'hA5, 8'hA5, 8'h5A, 8'hA5);
        do_single_op("toggle_0f", 3'd4, 8'h0F, 8'h0F, 8'h0F, 8'hAA);
    endtask

    task automatic test_set_clear;
        do_single_op("set", 3'd2, 8'h00, 8'hFF, 8'h00, 8'hFF);
        do_single_op("clear", 3'd1, 8'hFF, 8'h00, 8'hFF, 8'h00);
    endtask

    task automatic test_count_up;
        logic [7:0] eq [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        logic       ew [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_single_op("load_fd", 3'd3, 8'hFD, 8'hFD, 8'h02, 8'hFD);
        issue(3'd5, 8'h00, 8'd4);
        checks++; if ({j_out, k_out, busy} !== {8'h03, 8'h03, 1'b1}) begin errors++; $display("FAIL up_first_t: got %h/%h busy %b want 03/03 1", j_out, k_out, busy); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({q, wrap, done, busy} !== {eq[i], ew[i], i == 3, i != 3}) begin
                errors++; $display("FAIL up_step%0d: q %h wrap %b done %b busy %b want %h %b %b %b", i + 1, q, wrap, done, busy, eq[i], ew[i], i == 3, i != 3);
            end
        end
        @(negedge clk);
        checks++; if ({cmd_ready, done, wrap, q} !== {3'b100, 8'h01}) begin errors++; $display("FAIL up_idle: got %b %h want 100 01", {cmd_ready, done, wrap}, q); end
    endtask

    task automatic test_count_down;
        logic [7:0] eq [3] = '{8'h01, 8'h00, 8'hFF};
        logic       ew [3] = '{1'b0, 1'b0, 1'b1};
        int busy_cycles = 0;
        do_single_op("load_02", 3'd3, 8'h02, 8'h02, 8'hFD, 8'h02);
        issue(3'd6, 8'h00, 8'd3);
        busy_cycles += int'(busy);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            busy_cycles += int'(busy);
            checks++; if ({q, wrap, done} !== {eq[i], ew[i], i == 2}) begin
                errors++; $display("FAIL down_step%0d: q %h wrap %b done %b want %h %b %b", i + 1, q, wrap, done, eq[i], ew[i], i == 2);
            end
        end
        @(negedge clk);
        busy_cycles += int'(busy);
        checks++; if (busy_cycles !== 3) begin errors++; $display("FAIL down_busy_cycles: got %0d want 3", busy_cycles); end
        checks++; if ({cmd_ready, wrap} !== 2'b10) begin errors++; $display("FAIL down_idle: got %b want 10", {cmd_ready, wrap}); end
    endtask

    task automatic test_zero_and_reserved;
        issue(3'd5, 8'h00, 8'd0);
        checks++; if ({done, err, busy, cmd_ready, q} !== {4'b1000, 8'hFF}) begin errors++; $display("FAIL zero_count: got %b %h want 1000 ff", {done, err, busy, cmd_ready}, q); end
        @(negedge clk);
        checks++; if ({done, cmd_ready, q} !== {2'b01, 8'hFF}) begin errors++; $display("FAIL zero_idle: got %b %h want 01 ff", {done, cmd_ready}, q); end
        issue(3'd7, 8'h12, 8'd5);
        checks++; if ({done, err, busy, q} !== {3'b110, 8'hFF}) begin errors++; $display("FAIL rsvd_done: got %b %h want 110 ff", {done, err, busy}, q); end
        @(negedge clk);
        checks++; if ({done, err, cmd_ready} !== 3'b001) begin errors++; $display("FAIL rsvd_idle: got %b want 001", {done, err, cmd_ready}); end
    endtask

    task automatic test_reset_abort;
        int done_seen = 0;
        do_single_op("load_00", 3'd3, 8'h00, 8'h00, 8'hFF, 8'h00);
        issue(3'd5, 8'h00, 8'd200);
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_data = 8'h77;
        for (int i = 0; i < 49; i++) begin
            @(negedge clk);
            done_seen += int'(done);
        end
        checks++; if ({q, busy, done_seen[0]} !== {8'h31, 1'b1, 1'b0}) begin errors++; $display("FAIL abort_pre: q %h busy %b done_seen %0d want 31 1 0", q, busy, done_seen); end
        rst = 1'b0;
        #1;
        checks++; if ({q, j_out, k_out, busy, done, wrap} !== 27'h0) begin errors++; $display("FAIL abort_now: q %h j %h k %h flags %b want 0", q, j_out, k_out, {busy, done, wrap}); end
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if ({cmd_ready, q} !== {1'b1, 8'h00}) begin errors++; $display("FAIL abort_release: got %b %h want 1 00", cmd_ready, q); end
        repeat (3) @(negedge clk) done_seen += int'(done | busy);
        checks++; if ({done_seen, q} !== {32'd0, 8'h00}) begin errors++; $display("FAIL abort_after: activity %0d q %h want 0 00", done_seen, q); end
    endtask

    initial begin
        test_reset;
        test_load_toggle;
        test_set_clear;
        test_count_up;
        test_count_down;
        test_zero_and_reserved;
        test_reset_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
